multicycle_controller: RTL and testbench

Multicycle MIPS control FSM that drives the datapath ALU and captures its zero flag.
- Sequences fetch, decode, execute, memory and writeback for each instruction.
- Generates the 3-bit ALU opcode, mux selects and write strobes.
- Handshakes with unified instruction/data memory through mem_ready.

---
 rtl/multicycle_controller.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback and drives datapath selects.
// Latency (zero wait states, FETCH included): R-type 4, lw 5, sw 4, I-type ALU 4, beq/bne 3, j 3 cycles.
// Backpressure: FETCH, MEMRD and MEMWR stall on i_mem_ready=0; each stalled cycle adds one cycle, strobes never repeat.
//
// Ports:
//   i_clk, i_rst_n            clock (rising edge), asynchronous active-low reset
//   i_opcode, i_funct         instr[31:26] / instr[5:0] from the instruction register
//   i_zero                    ALU zero flag (branch condition)
//   i_mem_ready               unified memory completes the access this cycle
//   o_alu_control             000 add, 001 sub, 010 and, 011 or, 100 xor, 101 nor, 110 sll, 111 sra
//   o_alu_src_a / o_alu_src_b ALU operand selects (PC/A ; B/4/imm/imm<<2)
//   o_ext_zero                zero-extend the immediate (logical immediates)
//   o_pc_src, o_pc_write_en   PC source select and load enable
//   o_iord, o_ir_write        memory address select, IR load enable
//   o_mem_write, o_reg_write  memory / register-file write strobes
//   o_reg_dst, o_mem_to_reg   register write destination / data selects
//   o_instr_done              one-cycle pulse in the last cycle of every instruction
//   o_illegal_op              unsupported opcode/funct; held while in ILLEGAL
module multicycle_controller #(
  parameter bit MEM_HANDSHAKE = 1'b1,  // 0: memory assumed always ready
  parameter bit ILLEGAL_HALT  = 1'b1   // 1: ILLEGAL is terminal until reset
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  input  logic       i_zero,
  input  logic       i_mem_ready,
  output logic [2:0] o_alu_control,
  output logic       o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic       o_ext_zero,
  output logic [1:0] o_pc_src,
  output logic       o_pc_write_en,
  output logic       o_iord,
  output logic       o_ir_write,
  output logic       o_mem_write,
  output logic       o_reg_write,
  output logic       o_reg_dst,
  output logic       o_mem_to_reg,
  output logic       o_instr_done,
  output logic       o_illegal_op
);

  // FSM encoding
  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXEC    = 4'd6;
  localparam logic [3:0] S_ALUWB   = 4'd7;
  localparam logic [3:0] S_BRANCH  = 4'd8;
  localparam logic [3:0] S_IEXEC   = 4'd9;
  localparam logic [3:0] S_IWB     = 4'd10;
  localparam logic [3:0] S_JUMP    = 4'd11;
  localparam logic [3:0] S_ILLEGAL = 4'd12;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // ALU operations
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_NOR = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRA = 3'b111;

  // Supported R-type function codes
  function automatic logic funct_legal(input logic [5:0] f);
    case (f)
      6'h20, 6'h21, 6'h22, 6'h23,
      6'h24, 6'h25, 6'h26, 6'h27,
      6'h04, 6'h07: return 1'b1;
      default:      return 1'b0;
    endcase
  endfunction

  // R-type function code to ALU operation (only reached for legal codes)
  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    case (f)
      6'h20, 6'h21: return ALU_ADD;
      6'h22, 6'h23: return ALU_SUB;
      6'h24:        return ALU_AND;
      6'h25:        return ALU_OR;
      6'h26:        return ALU_XOR;
      6'h27:        return ALU_NOR;
      6'h04:        return ALU_SLL;
      6'h07:        return ALU_SRA;
      default:      return ALU_ADD;
    endcase
  endfunction

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic [5:0] r_op;
  logic [5:0] r_fn;
  logic       w_ready;

  assign w_ready = MEM_HANDSHAKE ? i_mem_ready : 1'b1;

  // Next-state logic. DECODE looks at the live IR fields; every later state
  // uses the copies captured at the end of DECODE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  if (w_ready) w_next = S_DECODE;
      S_DECODE: begin
        case (i_opcode)
          OP_RTYPE:                       w_next = funct_legal(i_funct) ? S_EXEC : S_ILLEGAL;
          OP_LW, OP_SW:                   w_next = S_MEMADR;
          OP_BEQ, OP_BNE:                 w_next = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: w_next = S_IEXEC;
          OP_J:                           w_next = S_JUMP;
          default:                        w_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR:  w_next = (r_op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   if (w_ready) w_next = S_MEMWB;
      S_MEMWR:   if (w_ready) w_next = S_FETCH;
      S_EXEC:    w_next = S_ALUWB;
      S_IEXEC:   w_next = S_IWB;
      S_MEMWB, S_ALUWB, S_IWB, S_BRANCH, S_JUMP: w_next = S_FETCH;
      S_ILLEGAL: w_next = ILLEGAL_HALT ? S_ILLEGAL : S_FETCH;
      default:   w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_FETCH;
      r_op    <= 6'h00;
      r_fn    <= 6'h00;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_op <= i_opcode;
        r_fn <= i_funct;
      end
    end
  end

  // Output decode (state only, plus mem_ready/zero gating on the strobes)
  logic [2:0] w_alu_control;
  logic       w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic       w_ext_zero;
  logic [1:0] w_pc_src;
  logic       w_pc_write_en;
  logic       w_iord;
  logic       w_ir_write;
  logic       w_mem_write;
  logic       w_reg_write;
  logic       w_reg_dst;
  logic       w_mem_to_reg;
  logic       w_instr_done;
  logic       w_illegal_op;

  always_comb begin
    w_alu_control = ALU_ADD;
    w_alu_src_a   = 1'b0;
    w_alu_src_b   = 2'b00;
    w_ext_zero    = 1'b0;
    w_pc_src      = 2'b00;
    w_pc_write_en = 1'b0;
    w_iord        = 1'b0;
    w_ir_write    = 1'b0;
    w_mem_write   = 1'b0;
    w_reg_write   = 1'b0;
    w_reg_dst     = 1'b0;
    w_mem_to_reg  = 1'b0;
    w_instr_done  = 1'b0;
    w_illegal_op  = 1'b0;
    case (r_state)
      S_FETCH: begin
        // PC+4 and IR load happen only in the cycle memory delivers
        w_alu_src_b   = 2'b01;
        w_ir_write    = w_ready;
        w_pc_write_en = w_ready;
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut
        w_alu_src_b = 2'b11;
      end
      S_MEMADR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        w_iord = 1'b1;
      end
      S_MEMWB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
        w_instr_done = 1'b1;
      end
      S_MEMWR: begin
        // Write strobe held for the whole access; done only when it lands
        w_iord       = 1'b1;
        w_mem_write  = 1'b1;
        w_instr_done = w_ready;
      end
      S_EXEC: begin
        w_alu_src_a   = 1'b1;
        w_alu_control = funct_alu(r_fn);
      end
      S_ALUWB: begin
        w_reg_write  = 1'b1;
        w_reg_dst    = 1'b1;
        w_instr_done = 1'b1;
      end
      S_BRANCH: begin
        w_alu_src_a   = 1'b1;
        w_alu_control = ALU_SUB;
        w_pc_src      = 2'b01;
        w_pc_write_en = (r_op == OP_BNE) ? ~i_zero : i_zero;
        w_instr_done  = 1'b1;
      end
      S_IEXEC: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
        case (r_op)
          OP_ANDI: begin w_alu_control = ALU_AND; w_ext_zero = 1'b1; end
          OP_ORI:  begin w_alu_control = ALU_OR;  w_ext_zero = 1'b1; end
          OP_XORI: begin w_alu_control = ALU_XOR; w_ext_zero = 1'b1; end
          default: w_alu_control = ALU_ADD;
        endcase
      end
      S_IWB: begin
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
      end
      S_JUMP: begin
        w_pc_src      = 2'b10;
        w_pc_write_en = 1'b1;
        w_instr_done  = 1'b1;
      end
      S_ILLEGAL: begin
        w_illegal_op = 1'b1;
      end
      default: begin
        w_alu_src_b = 2'b01;
      end
    endcase
  end

  // Selects come straight from the decode; the state is already FETCH
  // during reset so they show FETCH values.
  assign o_alu_control = w_alu_control;
  assign o_alu_src_a   = w_alu_src_a;
  assign o_alu_src_b   = w_alu_src_b;
  assign o_ext_zero    = w_ext_zero;
  assign o_pc_src      = w_pc_src;
  assign o_iord        = w_iord;
  assign o_reg_dst     = w_reg_dst;
  assign o_mem_to_reg  = w_mem_to_reg;

  // Strobes are forced low while reset is held, so a FETCH with
  // mem_ready high cannot load IR/PC during reset.
  assign o_pc_write_en = w_pc_write_en & i_rst_n;
  assign o_ir_write    = w_ir_write    & i_rst_n;
  assign o_mem_write   = w_mem_write   & i_rst_n;
  assign o_reg_write   = w_reg_write   & i_rst_n;
  assign o_instr_done  = w_instr_done  & i_rst_n;
  assign o_illegal_op  = w_illegal_op  & i_rst_n;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction expected control traces vs. two DUT instances.
// Latency: checks every cycle of every instruction, including memory wait cycles.
// Backpressure: mem_ready is held low for a chosen number of wait cycles in FETCH/MEMRD/MEMWR.
module tb_multicycle_controller;

  typedef struct packed {
    logic [2:0] alu;
    logic       sa;
    logic [1:0] sb;
    logic       ez;
    logic [1:0] ps;
    logic       pw;
    logic       iord;
    logic       irw;
    logic       mw;
    logic       rw;
    logic       rd;
    logic       m2r;
    logic       done;
    logic       ill;
  } ov_t;

  typedef struct {
    logic  mr;
    logic  dec;
    logic  z;
    ov_t   exp;
    string nm;
  } cyc_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic [5:0] funct = 6'h00;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;

  // Instance A: ILLEGAL_HALT=1 (checked every cycle)
  logic [2:0] a_alu;  logic a_sa; logic [1:0] a_sb; logic a_ez; logic [1:0] a_ps;
  logic a_pw, a_iord, a_irw, a_mw, a_rw, a_rd, a_m2r, a_done, a_ill;
  // Instance B: ILLEGAL_HALT=0 (checked around an illegal opcode)
  logic [2:0] b_alu;  logic b_sa; logic [1:0] b_sb; logic b_ez; logic [1:0] b_ps;
  logic b_pw, b_iord, b_irw, b_mw, b_rw, b_rd, b_m2r, b_done, b_ill;

  ov_t vec_a, vec_b;
  assign vec_a = {a_alu, a_sa, a_sb, a_ez, a_ps, a_pw, a_iord, a_irw, a_mw, a_rw, a_rd, a_m2r, a_done, a_ill};
  assign vec_b = {b_alu, b_sa, b_sb, b_ez, b_ps, b_pw, b_iord, b_irw, b_mw, b_rw, b_rd, b_m2r, b_done, b_ill};

  multicycle_controller #(.MEM_HANDSHAKE(1'b1), .ILLEGAL_HALT(1'b1)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_opcode(opcode), .i_funct(funct), .i_zero(zero),
    .i_mem_ready(mem_ready), .o_alu_control(a_alu), .o_alu_src_a(a_sa), .o_alu_src_b(a_sb),
    .o_ext_zero(a_ez), .o_pc_src(a_ps), .o_pc_write_en(a_pw), .o_iord(a_iord),
    .o_ir_write(a_irw), .o_mem_write(a_mw), .o_reg_write(a_rw), .o_reg_dst(a_rd),
    .o_mem_to_reg(a_m2r), .o_instr_done(a_done), .o_illegal_op(a_ill)
  );

  multicycle_controller #(.MEM_HANDSHAKE(1'b1), .ILLEGAL_HALT(1'b0)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_opcode(opcode), .i_funct(funct), .i_zero(zero),
    .i_mem_ready(mem_ready), .o_alu_control(b_alu), .o_alu_src_a(b_sa), .o_alu_src_b(b_sb),
    .o_ext_zero(b_ez), .o_pc_src(b_ps), .o_pc_write_en(b_pw), .o_iord(b_iord),
    .o_ir_write(b_irw), .o_mem_write(b_mw), .o_reg_write(b_rw), .o_reg_dst(b_rd),
    .o_mem_to_reg(b_m2r), .o_instr_done(b_done), .o_illegal_op(b_ill)
  );

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  bit   alt_on  = 1'b0;
  cyc_t q[$];

  task automatic check_eq(input string tag, input logic [17:0] got, input logic [17:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // ---------------- reference model ----------------
  // ALU op for a supported R-type funct; -1 when unsupported.
  function automatic int rtype_alu(input logic [5:0] f);
    case (f)
      6'h20, 6'h21: return 0;
      6'h22, 6'h23: return 1;
      6'h24:        return 2;
      6'h25:        return 3;
      6'h26:        return 4;
      6'h27:        return 5;
      6'h04:        return 6;
      6'h07:        return 7;
      default:      return -1;
    endcase
  endfunction

  function automatic ov_t v_fetch(input logic rdy);
    ov_t e = '0;
    e.sb  = 2'b01;
    e.pw  = rdy;
    e.irw = rdy;
    return e;
  endfunction

  task automatic push(input string nm, input logic mr, input logic dec, input logic z, input ov_t e);
    cyc_t c;
    c.nm = nm; c.mr = mr; c.dec = dec; c.z = z; c.exp = e;
    q.push_back(c);
  endtask

  // Expected cycle-by-cycle control trace of one instruction.
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw,
                       input logic bz, input int nill, output bit illegal);
    ov_t e;
    int  ra;
    q.delete();
    illegal = 1'b0;
    ra = rtype_alu(fn);
    for (int i = 0; i < fw; i++) push("fetch_wait", 1'b0, 1'b0, rbit(), v_fetch(1'b0));
    push("fetch", 1'b1, 1'b0, rbit(), v_fetch(1'b1));
    e = '0; e.sb = 2'b11;
    push("decode", rbit(), 1'b1, rbit(), e);
    if (op == 6'h00 && ra >= 0) begin
      e = '0; e.sa = 1'b1; e.alu = 3'(ra);
      push("exec", rbit(), 1'b0, rbit(), e);
      e = '0; e.rw = 1'b1; e.rd = 1'b1; e.done = 1'b1;
      push("aluwb", rbit(), 1'b0, rbit(), e);
    end else if (op == 6'h23 || op == 6'h2B) begin
      e = '0; e.sa = 1'b1; e.sb = 2'b10;
      push("memadr", rbit(), 1'b0, rbit(), e);
      if (op == 6'h23) begin
        e = '0; e.iord = 1'b1;
        for (int i = 0; i < mw; i++) push("memrd_wait", 1'b0, 1'b0, rbit(), e);
        push("memrd", 1'b1, 1'b0, rbit(), e);
        e = '0; e.rw = 1'b1; e.m2r = 1'b1; e.done = 1'b1;
        push("memwb", rbit(), 1'b0, rbit(), e);
      end else begin
        e = '0; e.iord = 1'b1; e.mw = 1'b1;
        for (int i = 0; i < mw; i++) push("memwr_wait", 1'b0, 1'b0, rbit(), e);
        e.done = 1'b1;
        push("memwr", 1'b1, 1'b0, rbit(), e);
      end
    end else if (op == 6'h04 || op == 6'h05) begin
      e = '0; e.sa = 1'b1; e.alu = 3'b001; e.ps = 2'b01; e.done = 1'b1;
      e.pw = (op == 6'h04) ? bz : ~bz;
      push("branch", rbit(), 1'b0, bz, e);
    end else if (op == 6'h08 || op == 6'h0C || op == 6'h0D || op == 6'h0E) begin
      e = '0; e.sa = 1'b1; e.sb = 2'b10;
      e.ez  = (op != 6'h08);
      e.alu = (op == 6'h0C) ? 3'b010 : (op == 6'h0D) ? 3'b011 : (op == 6'h0E) ? 3'b100 : 3'b000;
      push("iexec", rbit(), 1'b0, rbit(), e);
      e = '0; e.rw = 1'b1; e.done = 1'b1;
      push("iwb", rbit(), 1'b0, rbit(), e);
    end else if (op == 6'h02) begin
      e = '0; e.ps = 2'b10; e.pw = 1'b1; e.done = 1'b1;
      push("jump", rbit(), 1'b0, rbit(), e);
    end else begin
      illegal = 1'b1;
      e = '0; e.ill = 1'b1;
      for (int i = 0; i < nill; i++) push("illegal", rbit(), 1'b0, rbit(), e);
    end
  endtask

  // ---------------- stimulus ----------------
  // Tasks start and end right at a falling edge.
  task automatic do_reset();
    rst_n     = 1'b0;
    mem_ready = rbit();
    #1;
    check_eq("reset_vec", vec_a, v_fetch(1'b0));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic play(input logic [5:0] op, input logic [5:0] fn, input int rst_at);
    ov_t e_ill;
    e_ill = '0; e_ill.ill = 1'b1;
    for (int i = 0; i < q.size(); i++) begin
      mem_ready = q[i].mr;
      zero      = q[i].z;
      if (q[i].dec) begin
        opcode = op; funct = fn;
      end else begin
        opcode = 6'($urandom); funct = 6'($urandom);
      end
      #1;
      check_eq(q[i].nm, vec_a, q[i].exp);
      if (alt_on && i == 2) check_eq("halt0_illegal", vec_b, e_ill);
      if (alt_on && i == 3) check_eq("halt0_refetch", vec_b, v_fetch(q[i].mr));
      if (i == rst_at) begin
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_async_mem_write", {17'b0, a_mw}, 18'b0);
        check_eq("rst_mid_vec", vec_a, v_fetch(1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic run(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw,
                     input logic bz, input int nill, input int rst_at);
    bit ill;
    build(op, fn, fw, mw, bz, nill, ill);
    play(op, fn, rst_at);
    if (ill) do_reset();
  endtask

  logic [5:0] legal_ops [10] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h02};
  logic [5:0] legal_fns [10] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h04, 6'h07};

  initial begin
    @(negedge clk);
    do_reset();

    // Directed cases
    run(6'h00, 6'h20, 0, 0, 1'b0, 1, -1);   // add
    run(6'h23, 6'h00, 2, 3, 1'b0, 1, -1);   // lw with waits (10 cycles)
    run(6'h04, 6'h00, 0, 0, 1'b1, 1, -1);   // beq taken
    run(6'h04, 6'h00, 0, 0, 1'b0, 1, -1);   // beq not taken
    run(6'h05, 6'h00, 0, 0, 1'b0, 1, -1);   // bne taken
    run(6'h05, 6'h00, 0, 0, 1'b1, 1, -1);   // bne not taken
    run(6'h0D, 6'h00, 0, 0, 1'b0, 1, -1);   // ori
    run(6'h00, 6'h04, 0, 0, 1'b0, 1, -1);   // sllv
    run(6'h00, 6'h07, 0, 0, 1'b0, 1, -1);   // srav
    run(6'h2B, 6'h00, 1, 2, 1'b0, 1, -1);   // sw with waits
    run(6'h02, 6'h00, 0, 0, 1'b0, 1, -1);   // j
    run(6'h00, 6'h3A, 0, 0, 1'b0, 3, -1);   // unsupported funct

    // Illegal opcode: A holds 10 cycles, B refetches after one
    alt_on = 1'b1;
    run(6'h3F, 6'h00, 0, 0, 1'b0, 10, -1);
    alt_on = 1'b0;

    // Reset during a stalled store: fetch, decode, memadr, first memwr wait
    run(6'h2B, 6'h00, 0, 3, 1'b0, 1, 3);
    run(6'h00, 6'h27, 0, 0, 1'b0, 1, -1);   // nor right after reset

    // Randomized instruction stream
    for (int n = 0; n < 200; n++) begin
      logic [5:0] op, fn;
      op = ($urandom_range(0, 9) < 8) ? legal_ops[$urandom_range(0, 9)] : 6'($urandom);
      fn = ($urandom_range(0, 9) < 7) ? legal_fns[$urandom_range(0, 9)] : 6'($urandom);
      run(op, fn, $urandom_range(0, 2), $urandom_range(0, 2), rbit(), $urandom_range(1, 4), -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
